noc_traffic_top: RTL and testbench
==================================

// Module: noc_traffic_top
// PURPOSE
//  Self-contained traffic testbed top. N*N cores each run an 8-bit LFSR pulse generator that
//  produces random transfer requests. A round-robin allocator grants one core per cycle onto a
//  single shared registered channel, and a sink PE accumulates count and checksum. Needs only
//  clk/rst; all other ports are observation outputs for verification.
// PARAMETERS
//  DATA_W  8  channel payload width (8..32); payload = LFSR value zero-extended
//  N       2  core array dimension; CORES = N*N; IDX_W = max(1, clog2(CORES))
// PORTS
//  clk         in   1          single clock, all state on posedge
//  rst         in   1          reset, synchronous, active-low
//  gnt         out  CORES      one-hot allocator grant (combinational), 0 when none pending
//  chan_valid  out  1          registered channel valid
//  chan_data   out  DATA_W     registered channel payload
//  chan_src    out  IDX_W      registered index of granted core
//  xfer_cnt    out  16         transfers received by sink, wraps at 2^16
//  chk_sum     out  DATA_W+8   sum of received payloads, modulo 2^(DATA_W+8)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): lfsr[k] <= seed(k) = 8'h01 + 8'h1D*k (mod 256, k = 0..CORES-1;
//    any zero result is replaced by 8'hFF); pending=0, rr_ptr=0, chan_valid=0, chan_data=0,
//    chan_src=0, xfer_cnt=0, chk_sum=0. Reset mid-operation discards pending and in-flight data.
//  - LFSR per core, every non-reset cycle:
//    lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Never reaches 0.
//  - Pulse: pulse[k] = (lfsr[k][1:0]==2'b11), evaluated on the current (pre-shift) value.
//  - Core k: if pulse and !pending -> pending<=1, payload<=lfsr[k]. If pulse while pending
//    (including the grant cycle), the pulse is dropped; the old payload is kept.
//    When gnt[k]==1 -> pending<=0 next edge.
//  - Allocator: combinational. Search pending cores starting at rr_ptr, ascending with wrap;
//    grant the first one found. On any grant, rr_ptr <= (granted index + 1) mod CORES;
//    otherwise rr_ptr holds.
//  - Channel: chan_valid <= |gnt; when a grant is active, chan_data <= payload of the granted
//    core and chan_src <= its index; otherwise data/src hold. Latency is 1 cycle from grant.
//  - Sink: when chan_valid -> xfer_cnt <= xfer_cnt+1, chk_sum <= chk_sum + chan_data.
//    Latency is 2 cycles from grant.
//  - Throughput is at most 1 transfer/cycle. A core cannot be re-granted before its pending
//    flag is set again (minimum one cycle gap).
// CONFIGURATION
//  DROP_CNT_EN defined: adds output drop_cnt[15:0] (reset 0, wraps). It increments by the
//    number of cores with pulse && pending in a given cycle.
//  Undefined: the port and its logic are absent; dropped pulses are silently lost.
// TESTING
//  1. Hold rst=0 for 5 cycles -> gnt=0, chan_valid=0, xfer_cnt=0, chk_sum=0; lfsr0=8'h01,
//     lfsr1=8'h1E.
//  2. Release rst -> lfsr0 sequence 01,02,04,08,11; every chan_valid pulse has chan_data equal
//     to the LFSR value captured by core chan_src.
//  3. Force all four cores pending with rr_ptr=0 -> grants 0,1,2,3 in consecutive cycles;
//     chan_src follows 1 cycle later.
//  4. Run 100 cycles -> xfer_cnt equals the number of chan_valid cycles, chk_sum equals the
//     modular sum of chan_data, and gnt is always one-hot or zero.
//  5. Assert rst mid-run while chan_valid=1 -> next cycle all outputs are 0; counting restarts.
//  6. With DROP_CNT_EN: core pending and pulse asserted -> drop_cnt increments by 1 and the
//     payload is unchanged.

Source files
------------

// File: rtl/noc_traffic_top.sv
// N*N LFSR traffic cores -> round-robin allocator -> one registered channel -> sink (count + checksum).
// Latency: grant to chan_* 1 cycle, grant to xfer_cnt/chk_sum 2 cycles.
// Backpressure: none; losing cores stay pending, pulses on a pending core are dropped (counted with DROP_CNT_EN).
module noc_traffic_top #(
    parameter int DATA_W = 8,
    parameter int N      = 2,
    localparam int CORES = N * N,
    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1,
    localparam int SUM_W = DATA_W + 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [CORES-1:0]  gnt,
    output logic              chan_valid,
    output logic [DATA_W-1:0] chan_data,
    output logic [IDX_W-1:0]  chan_src,
    output logic [15:0]       xfer_cnt,
    output logic [SUM_W-1:0]  chk_sum
`ifdef DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    // Distinct non-zero seeds so the cores do not pulse in lockstep.
    function automatic logic [7:0] seed(input int k);
        logic [7:0] s;
        s = 8'(8'h01 + 8'h1D * k);
        if (s == 8'h00) s = 8'hFF;
        return s;
    endfunction

    logic [7:0]        lfsr_q    [CORES];
    logic [7:0]        lfsr_d    [CORES];
    logic [7:0]        payload_q [CORES];
    logic [7:0]        payload_d [CORES];
    logic [CORES-1:0]  pending_q, pending_d;
    logic [CORES-1:0]  pulse;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gnt_idx, cand;
    logic              gnt_any;
    logic              chan_valid_q, chan_valid_d;
    logic [DATA_W-1:0] chan_data_q, chan_data_d;
    logic [IDX_W-1:0]  chan_src_q, chan_src_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;
    logic [SUM_W-1:0]  chk_sum_q, chk_sum_d;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < CORES; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % CORES);
            if (!gnt_any && pending_q[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    // A granted core cannot capture a pulse in the same cycle; that pulse is dropped.
    always_comb begin
        lfsr_d    = lfsr_q;
        payload_d = payload_q;
        pending_d = pending_q;
        pulse     = '0;
        for (int k = 0; k < CORES; k++) begin
            pulse[k]  = (lfsr_q[k][1:0] == 2'b11);
            lfsr_d[k] = {lfsr_q[k][6:0], lfsr_q[k][7] ^ lfsr_q[k][5] ^ lfsr_q[k][4] ^ lfsr_q[k][3]};
            if (gnt[k]) begin
                pending_d[k] = 1'b0;
            end else if (pulse[k] && !pending_q[k]) begin
                pending_d[k] = 1'b1;
                payload_d[k] = lfsr_q[k];
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        chan_valid_d = gnt_any;
        chan_data_d  = chan_data_q;
        chan_src_d   = chan_src_q;
        if (gnt_any) begin
            rr_ptr_d    = (int'(gnt_idx) == CORES - 1) ? '0 : gnt_idx + 1'b1;
            chan_data_d = DATA_W'(payload_q[gnt_idx]);
            chan_src_d  = gnt_idx;
        end
        xfer_cnt_d = chan_valid_q ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
        chk_sum_d  = chan_valid_q ? chk_sum_q + SUM_W'(chan_data_q) : chk_sum_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < CORES; k++) begin
                lfsr_q[k]    <= seed(k);
                payload_q[k] <= '0;
            end
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            chan_valid_q <= 1'b0;
            chan_data_q  <= '0;
            chan_src_q   <= '0;
            xfer_cnt_q   <= '0;
            chk_sum_q    <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            payload_q    <= payload_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            chan_valid_q <= chan_valid_d;
            chan_data_q  <= chan_data_d;
            chan_src_q   <= chan_src_d;
            xfer_cnt_q   <= xfer_cnt_d;
            chk_sum_q    <= chk_sum_d;
        end
    end

    assign chan_valid = chan_valid_q;
    assign chan_data  = chan_data_q;
    assign chan_src   = chan_src_q;
    assign xfer_cnt   = xfer_cnt_q;
    assign chk_sum    = chk_sum_q;

`ifdef DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int k = 0; k < CORES; k++) begin
            if (pulse[k] && pending_q[k]) drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_traffic_top.sv
// Scoreboard bench for noc_traffic_top: a reference model predicts grants and pushes expected
// channel beats, which are popped and compared when the DUT raises chan_valid.
module tb_noc_traffic_top;
    localparam int DATA_W = 8;
    localparam int N      = 2;
    localparam int CORES  = N * N;
    localparam int IDX_W  = 2;
    localparam int SUM_W  = DATA_W + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CORES-1:0]  gnt;
    logic              chan_valid;
    logic [DATA_W-1:0] chan_data;
    logic [IDX_W-1:0]  chan_src;
    logic [15:0]       xfer_cnt;
    logic [SUM_W-1:0]  chk_sum;
`ifdef DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_traffic_top #(.DATA_W(DATA_W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .gnt        (gnt),
        .chan_valid (chan_valid),
        .chan_data  (chan_data),
        .chan_src   (chan_src),
        .xfer_cnt   (xfer_cnt),
        .chk_sum    (chk_sum)
`ifdef DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    // Reference model state (values held in DUT registers after the last edge).
    logic [7:0]              m_lfsr [CORES];
    logic [7:0]              m_pay  [CORES];
    logic [CORES-1:0]        m_pend;
    int                      m_rr;
    logic [15:0]             m_drop;
    logic [15:0]             obs_cnt;
    logic [SUM_W-1:0]        obs_sum;
    logic [IDX_W+DATA_W-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seed(input int k);
        logic [7:0] s;
        s = 8'(1 + 29 * k);
        if (s == 8'h00) s = 8'hFF;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CORES; k++) begin
            m_lfsr[k] = seed(k);
            m_pay[k]  = '0;
        end
        m_pend  = '0;
        m_rr    = 0;
        m_drop  = '0;
        obs_cnt = '0;
        obs_sum = '0;
        sb.delete();
    endtask

    // Called at a negedge with rst already set for the coming posedge; ends at the next negedge.
    task automatic one_cycle();
        logic [CORES-1:0]        eg;
        logic [IDX_W+DATA_W-1:0] exp_beat;
        logic                    pls;
        int                      gi;
        eg = '0;
        gi = -1;
        for (int i = 0; i < CORES; i++)
            if (gi < 0 && m_pend[(m_rr + i) % CORES]) gi = (m_rr + i) % CORES;
        if (gi >= 0) eg[gi] = 1'b1;

        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
        check("xfer_cnt", 32'(xfer_cnt), 32'(obs_cnt));
        check("chk_sum", 32'(chk_sum), 32'(obs_sum));
`ifdef DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        if (chan_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp_beat = sb.pop_front();
                check("chan_src", 32'(chan_src), 32'(exp_beat[IDX_W+DATA_W-1:DATA_W]));
                check("chan_data", 32'(chan_data), 32'(exp_beat[DATA_W-1:0]));
            end
            obs_cnt = obs_cnt + 16'd1;
            obs_sum = obs_sum + SUM_W'(chan_data);
        end

        if (!rst) begin
            model_reset();
        end else begin
            if (gi >= 0) sb.push_back({IDX_W'(gi), DATA_W'(m_pay[gi])});
            for (int k = 0; k < CORES; k++) begin
                pls = (m_lfsr[k][1:0] == 2'b11);
                if (pls && m_pend[k]) m_drop = m_drop + 16'd1;
                if (eg[k]) begin
                    m_pend[k] = 1'b0;
                end else if (pls && !m_pend[k]) begin
                    m_pend[k] = 1'b1;
                    m_pay[k]  = m_lfsr[k];
                end
                m_lfsr[k] = {m_lfsr[k][6:0], m_lfsr[k][7] ^ m_lfsr[k][5] ^ m_lfsr[k][4] ^ m_lfsr[k][3]};
            end
            if (gi >= 0) m_rr = (gi + 1) % CORES;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq [5];
        bit         seen;
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

        rst = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_chan_valid", 32'(chan_valid), 32'd0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_chk_sum", 32'(chk_sum), 32'd0);
        check("rst_lfsr0", 32'(dut.lfsr_q[0]), 32'h01);
        check("rst_lfsr1", 32'(dut.lfsr_q[1]), 32'h1E);

        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("lfsr0_seq", 32'(dut.lfsr_q[0]), 32'(seq[c]));
            one_cycle();
        end
        repeat (100) one_cycle();

        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (chan_valid) seen = 1'b1;
            else one_cycle();
        end
        check("wait_chan_valid", 32'(chan_valid), 32'd1);

        rst = 1'b0;
        one_cycle();
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_chan_valid", 32'(chan_valid), 32'd0);
        check("midrst_chan_data", 32'(chan_data), 32'd0);
        check("midrst_chan_src", 32'(chan_src), 32'd0);
        check("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        check("midrst_chk_sum", 32'(chk_sum), 32'd0);

        rst = 1'b1;
        repeat (150) one_cycle();
        check("xfer_nonzero", 32'(xfer_cnt != 16'd0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
